// File: rtl/ram_block_arbiter_if.sv
// Block-level trigger/ready bundles used around ram_block_arbiter.
//
// ram_block_arbiter_if      : one client port (cmd + data + blk_done).
//   master modport = client side, slave modport = arbiter side.
// ram_block_arbiter_ram_if  : the RAMController port (cmd + data).
//   master modport = arbiter side, slave modport = controller side.
//
// Signals:
//   cmd_ready/cmd_trigger/cmd_block/cmd_write : block request handshake
//   data_ready/data_trigger                   : per-word handshake
//   data_write/data_read                      : 16-bit word in each direction
//   blk_done (client only)                    : one-cycle block-complete pulse

interface ram_block_arbiter_if #(
    parameter int BlockWidth = 21
);
    logic                  cmd_ready;
    logic                  cmd_trigger;
    logic [BlockWidth-1:0] cmd_block;
    logic                  cmd_write;
    logic                  data_ready;
    logic                  data_trigger;
    logic [15:0]           data_write;
    logic [15:0]           data_read;
    logic                  blk_done;

    modport master (
        input  cmd_ready,
        output cmd_trigger, cmd_block, cmd_write,
        input  data_ready,
        output data_trigger, data_write,
        input  data_read, blk_done
    );

    modport slave (
        output cmd_ready,
        input  cmd_trigger, cmd_block, cmd_write,
        output data_ready,
        input  data_trigger, data_write,
        output data_read, blk_done
    );
endinterface

interface ram_block_arbiter_ram_if #(
    parameter int BlockWidth = 21
);
    logic                  cmd_ready;
    logic                  cmd_trigger;
    logic [BlockWidth-1:0] cmd_block;
    logic                  cmd_write;
    logic                  data_ready;
    logic                  data_trigger;
    logic [15:0]           data_write;
    logic [15:0]           data_read;

    modport master (
        input  cmd_ready,
        output cmd_trigger, cmd_block, cmd_write,
        input  data_ready,
        output data_trigger, data_write,
        input  data_read
    );

    modport slave (
        output cmd_ready,
        input  cmd_trigger, cmd_block, cmd_write,
        output data_ready,
        input  data_trigger, data_write,
        output data_read
    );
endinterface

// File: rtl/ram_block_arbiter.sv
// ram_block_arbiter: shares one RAMController between two block clients.
// A block is granted by round-robin command arbitration; the winner then owns
// the data path for exactly BlockSize word handshakes. All cmd/data paths are
// combinational pass-throughs.
//
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   p0   : client port 0 (arbiter side of ram_block_arbiter_if)
//   p1   : client port 1 (arbiter side of ram_block_arbiter_if)
//   ram  : RAMController port (ram_block_arbiter_ram_if)

module ram_block_arbiter #(
    parameter int BlockWidth = 21,
    parameter int BlockSize  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    ram_block_arbiter_if.slave      p0,
    ram_block_arbiter_if.slave      p1,
    ram_block_arbiter_ram_if.master ram
);
    localparam int                  CntWidth = $clog2(BlockSize);
    localparam logic [CntWidth-1:0] LastWord = CntWidth'(BlockSize - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state;
    state_t              state_nxt;
    logic                owner;
    logic                last;
    logic [CntWidth-1:0] wcnt;
    logic [1:0]          blk_done;

    logic sel;
    logic sel_trigger;
    logic owner_trigger;
    logic cmd_fire;
    logic data_fire;

    // Tie goes to the port that did not win last time; reset value of last=1
    // lets port 0 win the first tie.
    assign sel           = (p0.cmd_trigger && p1.cmd_trigger) ? !last : p1.cmd_trigger;
    assign sel_trigger   = sel ? p1.cmd_trigger : p0.cmd_trigger;
    assign owner_trigger = owner ? p1.data_trigger : p0.data_trigger;
    assign cmd_fire      = !rst && (state == IDLE) && sel_trigger && ram.cmd_ready;
    assign data_fire     = !rst && (state == BUSY) && owner_trigger && ram.data_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        p0.cmd_ready     = 1'b0;
        p1.cmd_ready     = 1'b0;
        p0.data_ready    = 1'b0;
        p1.data_ready    = 1'b0;
        ram.cmd_trigger  = 1'b0;
        ram.data_trigger = 1'b0;
        ram.cmd_block    = sel ? p1.cmd_block : p0.cmd_block;
        ram.cmd_write    = sel ? p1.cmd_write : p0.cmd_write;
        ram.data_write   = owner ? p1.data_write : p0.data_write;
        p0.data_read     = ram.data_read;
        p1.data_read     = ram.data_read;
        p0.blk_done      = blk_done[0];
        p1.blk_done      = blk_done[1];

        // Handshake outputs stay low for the whole time rst is asserted.
        if (!rst) begin
            case (state)
                IDLE: begin
                    ram.cmd_trigger = sel_trigger;
                    if (sel) begin
                        p1.cmd_ready = ram.cmd_ready;
                    end else begin
                        p0.cmd_ready = ram.cmd_ready;
                    end
                    if (cmd_fire) begin
                        state_nxt = BUSY;
                    end
                end
                BUSY: begin
                    ram.data_trigger = owner_trigger;
                    if (owner) begin
                        p1.data_ready = ram.data_ready;
                    end else begin
                        p0.data_ready = ram.data_ready;
                    end
                    if (data_fire && (wcnt == LastWord)) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner    <= 1'b0;
            last     <= 1'b1;
            wcnt     <= '0;
            blk_done <= '0;
        end else begin
            blk_done <= '0;
            if (cmd_fire) begin
                owner <= sel;
                last  <= sel;
                wcnt  <= '0;
            end else if (data_fire) begin
                if (wcnt == LastWord) begin
                    wcnt            <= '0;
                    blk_done[owner] <= 1'b1;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
            end
        end
    end
endmodule
